in_bits: RTL
============

IN_BITS -- requirements
Module: in_bits

Interface
REQ-001 The module SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port word_in, input, 16 bits: compressed-stream word, MSB is the earliest bit.
REQ-005 The module SHALL have port word_valid, input, 1 bit: word_in is valid.
REQ-006 The module SHALL have port word_ready, output, 1 bit: a word is accepted on word_valid && word_ready.
REQ-007 The module SHALL have port shift_count, input, 5 bits: number of bits to consume from the stream, 0..16.
REQ-008 The module SHALL have port shift_valid, input, 1 bit: shift_count is valid.
REQ-009 The module SHALL have port shift_ready, output, 1 bit: a shift is accepted on shift_valid && shift_ready.
REQ-010 The module SHALL have port flush, input, 1 bit: synchronous stream restart.
REQ-011 The module SHALL have port code_out, output, 16 bits: decoder code register.
REQ-012 The module SHALL have port code_valid, output, 1 bit: one-cycle pulse marking an updated code_out.

Function
REQ-013 The module SHALL hold a 32-bit bit reservoir, MSB-aligned, and a fill count of 0..32.
REQ-014 The module SHALL have two states, PRIME and RUN; the state after reset SHALL be PRIME.
REQ-015 word_ready SHALL equal (fill <= 16) and SHALL be derived only from registered state.
REQ-016 An accepted word SHALL be written into the reservoir immediately below the valid bits remaining after that cycle's consumption.
REQ-017 In PRIME with fill >= 16, the module SHALL load code_out from the top 16 reservoir bits, reduce fill by 16, pulse code_valid on the next cycle, and enter RUN.
REQ-018 shift_ready SHALL equal (state == RUN) && (fill >= effective shift_count).
REQ-019 On an accepted shift of n bits, code_out SHALL become {code_out << n} with the low n bits taken from the top n reservoir bits.
REQ-020 On an accepted shift, fill SHALL decrease by n, and code_valid SHALL pulse on the following cycle (latency 1).
REQ-021 A shift_count above 16 SHALL be treated as 16.
REQ-022 A shift_count of 0 SHALL always be accepted in RUN, SHALL leave code_out unchanged, and SHALL still pulse code_valid.
REQ-023 When a word accept and a shift accept occur in the same cycle, the shift SHALL consume pre-existing bits first, and the new fill SHALL be fill - n + 16.
REQ-024 flush SHALL take priority over all other events: it clears the reservoir, sets fill to 0, enters PRIME and suppresses code_valid; any word presented in the flush cycle SHALL be dropped.
REQ-025 Input on word_* and shift_* SHALL be ignored while in reset.

Reset
REQ-026 While rst_n is low, the module SHALL hold state=PRIME, fill=0, reservoir=0, code_out=0x0000 and code_valid=0.
REQ-027 While rst_n is low, shift_ready SHALL be 0, and word_ready SHALL be 1 but ignored.
REQ-028 Reset asserted mid-operation SHALL discard all buffered bits immediately, with no residual code_valid pulse.

Structure
REQ-029 The shared package arith_coder_pkg SHALL hold CODE_W=16, CNT_W=5, RES_W=32 and the PRIME/RUN state enum.
REQ-030 Reservoir storage, fill tracking and the shift/append datapath SHALL be in sub-module bit_reservoir; the FSM, handshakes and code register SHALL be in in_bits.

Verification
REQ-031 Prime scenario: after reset, push 0xA5C3 -> one cycle later code_out=0xA5C3 with a 1-cycle code_valid pulse, and shift_ready=0 until the next word arrives.
REQ-032 Shift-4 scenario: primed 0xA5C3, push 0x1234, shift 4 -> code_out=0x5C31, fill=12.
REQ-033 Full-drain scenario: fill=16 holding 0xBEEF, shift 16 -> code_out=0xBEEF; then shift 1 stalls (shift_ready=0) while shift 0 is accepted and pulses code_valid.
REQ-034 Simultaneous scenario: fill=16, word 0xFFFF and shift 8 in the same cycle -> fill=24, and the top 8 reservoir bits follow the consumed ones in order.
REQ-035 Backpressure scenario: fill=24 -> word_ready=0 and word_valid is held without loss until a shift of at least 8 is accepted.
REQ-036 Flush/reset scenario: flush or rst_n low mid-stream -> fill=0, PRIME, no code_valid, and the next pushed word re-primes code_out exactly.

Source files
------------

// File: rtl/arith_coder_pkg.sv
// Shared widths and control-state encoding for the compressed-stream bit feeder.
package arith_coder_pkg;

  localparam int unsigned CODE_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned FILL_W = 6;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Requests beyond one code word consume exactly one code word.
  function automatic logic [CNT_W-1:0] clamp_shift(input logic [CNT_W-1:0] count);
    return (count > CNT_W'(CODE_W)) ? CNT_W'(CODE_W) : count;
  endfunction

endpackage

// File: rtl/in_bits_if.sv
// Word-in / shift-request / code-out bundle between a stream source and in_bits.
interface in_bits_if;
  import arith_coder_pkg::*;

  logic [CODE_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [CNT_W-1:0]  shift_count;
  logic              shift_valid;
  logic              shift_ready;
  logic              flush;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;

  modport master (
    output word_in, word_valid, shift_count, shift_valid, flush,
    input  word_ready, shift_ready, code_out, code_valid
  );

  modport slave (
    input  word_in, word_valid, shift_count, shift_valid, flush,
    output word_ready, shift_ready, code_out, code_valid
  );

endinterface

// File: rtl/bit_reservoir.sv
// MSB-aligned 32-bit bit reservoir: consume from the top, append a word below the survivors.
module bit_reservoir
  import arith_coder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [CNT_W-1:0]  consume,
  input  logic              push,
  input  logic [CODE_W-1:0] word,
  output logic [RES_W-1:0]  res,
  output logic [FILL_W-1:0] fill
);

  logic [RES_W-1:0]  kept;
  logic [RES_W-1:0]  appended;
  logic [FILL_W-1:0] left;

  // Bits below fill are always zero, so an OR places the new word cleanly.
  always_comb begin
    kept     = res << consume;
    left     = fill - FILL_W'(consume);
    appended = {word, CODE_W'(0)} >> left;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res  <= '0;
      fill <= '0;
    end else if (clear) begin
      res  <= '0;
      fill <= '0;
    end else begin
      res  <= push ? (kept | appended) : kept;
      fill <= left + (push ? FILL_W'(CODE_W) : FILL_W'(0));
    end
  end

endmodule

// File: rtl/in_bits.sv
// Decoder input stage: primes a 16-bit code register from the stream, then shifts in n bits per request.
module in_bits
  import arith_coder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  in_bits_if.slave   bus
);

  state_t              state;
  logic [CODE_W-1:0]   code;
  logic                code_v;
  logic [RES_W-1:0]    res;
  logic [FILL_W-1:0]   fill;
  logic [CNT_W-1:0]    n_eff;
  logic [CNT_W-1:0]    consume;
  logic                prime_go;
  logic                shift_go;
  logic                word_go;
  logic [2*CODE_W-1:0] code_cat;

  // Handshakes come from registered fill/state; shift_ready also looks at the request size.
  always_comb begin
    n_eff           = clamp_shift(bus.shift_count);
    bus.word_ready  = (fill <= FILL_W'(CODE_W));
    bus.shift_ready = (state == RUN) && (fill >= FILL_W'(n_eff));
    prime_go        = (state == PRIME) && (fill >= FILL_W'(CODE_W));
    shift_go        = bus.shift_valid && bus.shift_ready;
    word_go         = bus.word_valid && bus.word_ready && !bus.flush;
    consume         = prime_go ? CNT_W'(CODE_W) : (shift_go ? n_eff : CNT_W'(0));
    code_cat        = {code, res[RES_W-1 -: CODE_W]} << n_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PRIME;
      code   <= '0;
      code_v <= 1'b0;
    end else if (bus.flush) begin
      state  <= PRIME;
      code_v <= 1'b0;
    end else begin
      code_v <= 1'b0;
      if (prime_go) begin
        code   <= res[RES_W-1 -: CODE_W];
        code_v <= 1'b1;
        state  <= RUN;
      end else if (shift_go) begin
        code   <= code_cat[2*CODE_W-1 -: CODE_W];
        code_v <= 1'b1;
      end
    end
  end

  assign bus.code_out   = code;
  assign bus.code_valid = code_v;

  bit_reservoir u_res (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.flush),
    .consume (consume),
    .push    (word_go),
    .word    (bus.word_in),
    .res     (res),
    .fill    (fill)
  );

endmodule
